// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: display value/decimal-point inputs and scanned anode/cathode outputs
interface seven_seg_scan_if;
    logic [31:0] SEVENSEGHEX;
    logic [7:0]  DP_IN;
    logic        LZB;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        FRAME;
    modport master (output SEVENSEGHEX, DP_IN, LZB, input AN, SEG, DP, FRAME);
    modport slave (input SEVENSEGHEX, DP_IN, LZB, output AN, SEG, DP, FRAME);
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 8-digit common-anode hex scanner with per-frame latching, dark guard slot and leading-zero blanking
module seven_seg_scan #(
    parameter int CLK_DIV = 100000
) (
    input logic            CLK,
    input logic            RESET,
    seven_seg_scan_if.slave bus
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic [2:0]   r_idx;
    logic [31:0]  r_shadow;
    logic [7:0]   r_dots;
    logic [7:0]   r_blank;
    logic         r_guard;
    logic [7:0]   r_an;
    logic [6:0]   r_seg;
    logic         r_dp;
    logic         r_frame;

    logic         w_tick;
    logic         w_latch;
    logic         w_dark;
    logic [2:0]   w_idx_nxt;
    logic [3:0]   w_nib;
    logic [7:0]   w_blank;
    logic [6:0]   w_seg;

    assign w_tick    = r_cnt == LAST;
    assign w_idx_nxt = r_idx + 3'd1;
    assign w_latch   = w_tick && w_idx_nxt == 3'd0;
    assign w_dark    = bus.LZB && r_blank[r_idx];
    assign w_nib     = r_shadow[{r_idx, 2'b00} +: 4];

    assign bus.AN    = r_an;
    assign bus.SEG   = r_seg;
    assign bus.DP    = r_dp;
    assign bus.FRAME = r_frame;

    // Digit i is blankable when every nibble from i up to 7 is zero
    always_comb begin
        logic z;
        z = 1'b1;
        w_blank = '0;
        for (int i = 7; i >= 1; i--) begin
            z = z && bus.SEVENSEGHEX[4*i +: 4] == 4'h0;
            w_blank[i] = z;
        end
    end

    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            default: w_seg = 7'h0E;
        endcase
    end

    // A tick edge forces one dark cycle before the new digit is driven, avoiding ghosting
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt    <= '0;
            r_idx    <= 3'd7;
            r_shadow <= '0;
            r_dots   <= '0;
            r_blank  <= '0;
            r_guard  <= 1'b0;
            r_an     <= 8'hFF;
            r_seg    <= 7'h7F;
            r_dp     <= 1'b1;
            r_frame  <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_frame <= w_latch;
            if (w_tick) begin
                r_idx   <= w_idx_nxt;
                r_an    <= 8'hFF;
                r_seg   <= 7'h7F;
                r_dp    <= 1'b1;
                r_guard <= 1'b1;
            end else if (r_guard) begin
                r_guard <= 1'b0;
                r_an    <= w_dark ? 8'hFF : ~(8'b1 << r_idx);
                r_seg   <= w_dark ? 7'h7F : w_seg;
                r_dp    <= w_dark | ~r_dots[r_idx];
            end
            if (w_latch) begin
                r_shadow <= bus.SEVENSEGHEX;
                r_dots   <= bus.DP_IN;
                r_blank  <= w_blank;
            end
        end
    end
endmodule
